// File: rtl/atm_pkg.sv
// Shared encodings for the ATM session controller: FSM states, response codes,
// service and language selectors.
package atm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LANG     = 4'd1,
    ST_PIN      = 4'd2,
    ST_SERVICE  = 4'd3,
    ST_DEPOSIT  = 4'd4,
    ST_WITHDRAW = 4'd5,
    ST_BALANCE  = 4'd6,
    ST_ANOTHER  = 4'd7,
    ST_EJECT    = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    RESP_OK       = 3'd0,
    RESP_BAD_PIN  = 3'd1,
    RESP_LOCKED   = 3'd2,
    RESP_INSUFF   = 3'd3,
    RESP_OVERFLOW = 3'd4,
    RESP_TIMEOUT  = 3'd5,
    RESP_BAD_REQ  = 3'd6
  } resp_e;

  localparam logic [2:0] SVC_DEPOSIT  = 3'b001;
  localparam logic [2:0] SVC_WITHDRAW = 3'b010;
  localparam logic [2:0] SVC_BALANCE  = 3'b011;

  localparam logic [1:0] LANG_EN = 2'b01;
  localparam logic [1:0] LANG_DE = 2'b10;

  // States that wait on a customer strobe and are therefore subject to timeout.
  function automatic logic is_wait_state(input state_e s);
    return s inside {ST_LANG, ST_PIN, ST_SERVICE, ST_DEPOSIT, ST_WITHDRAW, ST_ANOTHER};
  endfunction

endpackage

// File: rtl/atm_timeout_timer.sv
// Idle-cycle down-counter: reloads on clr, counts while en, flags expiry
// during the TIMEOUT-th idle cycle after the last clear.
module atm_timeout_timer #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // expired is kept equal to (cnt_q == 0) so it comes straight from a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= LOAD;
      expired <= 1'b0;
    end else if (clr) begin
      cnt_q   <= LOAD;
      expired <= 1'b0;
    end else if (en && (cnt_q != '0)) begin
      cnt_q   <= cnt_q - CNT_W'(1);
      expired <= (cnt_q == CNT_W'(1));
    end
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// Multi-account ATM session controller: card, language, PIN with lockout,
// deposit/withdraw/balance services, per-state timeout, coded responses.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int unsigned NUM_ACCTS = 4,
  parameter int unsigned BAL_W     = 16,
  parameter int unsigned PIN_W     = 16,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned INIT_BAL  = 100,
  localparam int unsigned ID_W     = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 card_valid,
  input  logic [ID_W-1:0]      card_id,
  input  logic                 lang_valid,
  input  logic [1:0]           lang,
  input  logic                 pin_valid,
  input  logic [PIN_W-1:0]     pin,
  input  logic                 svc_valid,
  input  logic [2:0]           svc,
  input  logic                 amt_valid,
  input  logic [BAL_W-1:0]     amt,
  input  logic                 more_valid,
  input  logic                 more,
  input  logic                 cfg_we,
  input  logic [ID_W-1:0]      cfg_idx,
  input  logic [PIN_W-1:0]     cfg_pin,
  output logic                 busy,
  output logic                 resp_valid,
  output logic [2:0]           resp_code,
  output logic [BAL_W-1:0]     balance_o,
  output logic [1:0]           lang_o,
  output logic [NUM_ACCTS-1:0] locked,
  output logic                 card_eject
);

  localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [1:0]         lang_d;
  logic               resp_valid_d, eject_d, busy_d;
  resp_e              resp_code_d;
  logic [BAL_W-1:0]   balance_d;

  logic [BAL_W-1:0]   bal_q [NUM_ACCTS];
  logic [PIN_W-1:0]   pin_q [NUM_ACCTS];

  logic               acc, timer_clr, expired;
  logic               bal_we, pin_we, lock_set;
  logic [BAL_W-1:0]   bal_wdata, cur_bal;
  logic [BAL_W:0]     dep_sum;

  atm_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .en      (is_wait_state(state_q)),
    .expired (expired)
  );

  // Next-state, response and table-write decode
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    tries_d      = tries_q;
    lang_d       = lang_o;
    resp_valid_d = 1'b0;
    resp_code_d  = RESP_OK;
    eject_d      = 1'b0;
    acc          = 1'b0;
    bal_we       = 1'b0;
    pin_we       = 1'b0;
    lock_set     = 1'b0;
    cur_bal      = bal_q[id_q];
    bal_wdata    = cur_bal;
    dep_sum      = {1'b0, amt} + {1'b0, cur_bal};
    timer_clr    = 1'b0;
    busy_d       = 1'b0;
    balance_d    = '0;

    unique case (state_q)
      ST_IDLE: begin
        // a config write owns the cycle; a simultaneous card is dropped
        if (cfg_we) begin
          pin_we = 1'b1;
        end else if (card_valid) begin
          if (locked[card_id]) begin
            resp_valid_d = 1'b1;
            resp_code_d  = RESP_LOCKED;
            state_d      = ST_EJECT;
          end else begin
            id_d    = card_id;
            tries_d = '0;
            state_d = ST_LANG;
          end
        end
      end
      ST_LANG: begin
        if (lang_valid) begin
          acc = 1'b1;
          if ((lang == LANG_EN) || (lang == LANG_DE)) begin
            lang_d  = lang;
            state_d = ST_PIN;
          end else begin
            resp_valid_d = 1'b1;
            resp_code_d  = RESP_BAD_REQ;
          end
        end
      end
      ST_PIN: begin
        if (pin_valid) begin
          acc          = 1'b1;
          resp_valid_d = 1'b1;
          if (pin == pin_q[id_q]) begin
            tries_d = '0;
            state_d = ST_SERVICE;
          end else if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
            lock_set    = 1'b1;
            resp_code_d = RESP_LOCKED;
            state_d     = ST_EJECT;
          end else begin
            tries_d     = tries_q + TRY_W'(1);
            resp_code_d = RESP_BAD_PIN;
          end
        end
      end
      ST_SERVICE: begin
        if (svc_valid) begin
          acc = 1'b1;
          case (svc)
            SVC_DEPOSIT:  state_d = ST_DEPOSIT;
            SVC_WITHDRAW: state_d = ST_WITHDRAW;
            SVC_BALANCE:  state_d = ST_BALANCE;
            default: begin
              resp_valid_d = 1'b1;
              resp_code_d  = RESP_BAD_REQ;
            end
          endcase
        end
      end
      ST_DEPOSIT: begin
        if (amt_valid) begin
          acc          = 1'b1;
          resp_valid_d = 1'b1;
          if (amt == '0) begin
            resp_code_d = RESP_BAD_REQ;
          end else begin
            state_d = ST_ANOTHER;
            if (dep_sum[BAL_W]) begin
              resp_code_d = RESP_OVERFLOW;
            end else begin
              bal_we    = 1'b1;
              bal_wdata = dep_sum[BAL_W-1:0];
            end
          end
        end
      end
      ST_WITHDRAW: begin
        if (amt_valid) begin
          acc          = 1'b1;
          resp_valid_d = 1'b1;
          if (amt == '0) begin
            resp_code_d = RESP_BAD_REQ;
          end else begin
            state_d = ST_ANOTHER;
            if (amt > cur_bal) begin
              resp_code_d = RESP_INSUFF;
            end else begin
              bal_we    = 1'b1;
              bal_wdata = cur_bal - amt;
            end
          end
        end
      end
      ST_BALANCE: begin
        resp_valid_d = 1'b1;
        state_d      = ST_ANOTHER;
      end
      ST_ANOTHER: begin
        if (more_valid) begin
          acc     = 1'b1;
          state_d = more ? ST_SERVICE : ST_EJECT;
        end
      end
      ST_EJECT: begin
        eject_d = 1'b1;
        id_d    = '0;
        tries_d = '0;
        lang_d  = 2'b00;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // a strobe in the expiry cycle wins over the timeout
    if (is_wait_state(state_q) && !acc && expired) begin
      resp_valid_d = 1'b1;
      resp_code_d  = RESP_TIMEOUT;
      state_d      = ST_EJECT;
    end

    timer_clr = acc || (state_d != state_q);
    busy_d    = (state_d != ST_IDLE);
    if (state_d != ST_IDLE) begin
      balance_d = bal_we ? bal_wdata : bal_q[id_d];
    end
  end

  // Session state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      id_q       <= '0;
      tries_q    <= '0;
      lang_o     <= 2'b00;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_code  <= 3'd0;
      balance_o  <= '0;
      card_eject <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      tries_q    <= tries_d;
      lang_o     <= lang_d;
      busy       <= busy_d;
      resp_valid <= resp_valid_d;
      resp_code  <= resp_code_d;
      balance_o  <= balance_d;
      card_eject <= eject_d;
    end
  end

  // Balance, PIN and lock tables; reset restores the power-on contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ACCTS; i++) begin
        bal_q[i] <= BAL_W'(INIT_BAL);
        pin_q[i] <= '0;
      end
      locked <= '0;
    end else begin
      if (bal_we)   bal_q[id_q]    <= bal_wdata;
      if (pin_we)   pin_q[cfg_idx] <= cfg_pin;
      if (lock_set) locked[id_q]   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed and randomized session bench for atm_session_ctrl with a
// transaction-level account model (balances, PINs, locks).
module tb_atm_session_ctrl;

  localparam int NA        = 4;
  localparam int ID_W      = 2;
  localparam int BAL_W     = 8;
  localparam int PIN_W     = 16;
  localparam int MAX_TRIES = 3;
  localparam int TMO       = 8;
  localparam int INIT_BAL  = 100;
  localparam int BAL_MAX   = (1 << BAL_W) - 1;

  localparam int R_OK = 0, R_BAD_PIN = 1, R_LOCKED = 2, R_INSUFF = 3;
  localparam int R_OVERFLOW = 4, R_TIMEOUT = 5, R_BAD_REQ = 6;

  localparam int K_NONE = 0, K_CARD = 1, K_LANG = 2, K_PIN = 3, K_SVC = 4;
  localparam int K_AMT = 5, K_MORE = 6, K_CFG = 7, K_CFG_CARD = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             card_valid, lang_valid, pin_valid, svc_valid, amt_valid, more_valid, cfg_we;
  logic [ID_W-1:0]  card_id, cfg_idx;
  logic [1:0]       lang;
  logic [PIN_W-1:0] pin, cfg_pin;
  logic [2:0]       svc;
  logic [BAL_W-1:0] amt;
  logic             more;
  logic             busy, resp_valid, card_eject;
  logic [2:0]       resp_code;
  logic [BAL_W-1:0] balance_o;
  logic [1:0]       lang_o;
  logic [NA-1:0]    locked;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned      m_bal [NA];
  logic [PIN_W-1:0] m_pin [NA];
  logic [NA-1:0]    m_lock;
  int               m_id, m_svc, m_tries;

  atm_session_ctrl #(
    .NUM_ACCTS(NA), .BAL_W(BAL_W), .PIN_W(PIN_W), .MAX_TRIES(MAX_TRIES),
    .TIMEOUT(TMO), .INIT_BAL(INIT_BAL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .card_valid(card_valid), .card_id(card_id),
    .lang_valid(lang_valid), .lang(lang),
    .pin_valid(pin_valid), .pin(pin),
    .svc_valid(svc_valid), .svc(svc),
    .amt_valid(amt_valid), .amt(amt),
    .more_valid(more_valid), .more(more),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pin(cfg_pin),
    .busy(busy), .resp_valid(resp_valid), .resp_code(resp_code),
    .balance_o(balance_o), .lang_o(lang_o), .locked(locked),
    .card_eject(card_eject)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input bit v, input int code);
    check({tag, "_valid"}, 32'(resp_valid), 32'(v));
    if (v) check({tag, "_code"}, 32'(resp_code), 32'(code));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      m_bal[i] = INIT_BAL;
      m_pin[i] = '0;
    end
    m_lock = '0;
  endtask

  // Drive one strobe for one clock from a falling edge; return on the next falling edge.
  task automatic send(input int kind, input int unsigned a, input int unsigned b);
    case (kind)
      K_CARD:     begin card_valid = 1'b1; card_id = ID_W'(a); end
      K_LANG:     begin lang_valid = 1'b1; lang = 2'(a); end
      K_PIN:      begin pin_valid = 1'b1; pin = PIN_W'(a); end
      K_SVC:      begin svc_valid = 1'b1; svc = 3'(a); end
      K_AMT:      begin amt_valid = 1'b1; amt = BAL_W'(a); end
      K_MORE:     begin more_valid = 1'b1; more = 1'(a); end
      K_CFG:      begin cfg_we = 1'b1; cfg_idx = ID_W'(a); cfg_pin = PIN_W'(b); end
      K_CFG_CARD: begin
        cfg_we = 1'b1; cfg_idx = ID_W'(a); cfg_pin = PIN_W'(b);
        card_valid = 1'b1; card_id = ID_W'(a);
      end
      default: ;
    endcase
    @(negedge clk);
    card_valid = 1'b0; lang_valid = 1'b0; pin_valid = 1'b0; svc_valid = 1'b0;
    amt_valid = 1'b0; more_valid = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic eject_seq(input string tag);
    send(K_NONE, 0, 0);
    check({tag, "_eject"}, 32'(card_eject), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_bal0"}, 32'(balance_o), 0);
    check({tag, "_lang0"}, 32'(lang_o), 0);
    chk_resp(tag, 1'b0, 0);
    send(K_NONE, 0, 0);
    check({tag, "_pulse"}, 32'(card_eject), 0);
  endtask

  task automatic t_card(input int id, output bit ok);
    send(K_CARD, id, 0);
    if (m_lock[id]) begin
      chk_resp("card_locked", 1'b1, R_LOCKED);
      check("card_locked_busy", 32'(busy), 1);
      eject_seq("lock_eject");
      ok = 1'b0;
    end else begin
      chk_resp("card", 1'b0, 0);
      check("card_busy", 32'(busy), 1);
      check("card_bal", 32'(balance_o), m_bal[id]);
      m_id = id;
      m_tries = 0;
      ok = 1'b1;
    end
  endtask

  task automatic t_lang(input int l, output bit ok);
    send(K_LANG, l, 0);
    ok = (l == 1) || (l == 2);
    if (ok) begin
      chk_resp("lang", 1'b0, 0);
      check("lang_o", 32'(lang_o), l);
    end else begin
      chk_resp("lang_bad", 1'b1, R_BAD_REQ);
      check("lang_o_bad", 32'(lang_o), 0);
    end
  endtask

  // st: 0 accepted, 1 rejected, 2 card locked and ejected
  task automatic t_pin(input logic [PIN_W-1:0] p, output int st);
    send(K_PIN, p, 0);
    if (p == m_pin[m_id]) begin
      chk_resp("pin_ok", 1'b1, R_OK);
      m_tries = 0;
      st = 0;
    end else begin
      m_tries++;
      if (m_tries == MAX_TRIES) begin
        chk_resp("pin_lock", 1'b1, R_LOCKED);
        m_lock[m_id] = 1'b1;
        check("locked_bits", 32'(locked), 32'(m_lock));
        eject_seq("pin_eject");
        st = 2;
      end else begin
        chk_resp("pin_bad", 1'b1, R_BAD_PIN);
        st = 1;
      end
    end
  endtask

  task automatic t_svc(input int s, output bit ok);
    send(K_SVC, s, 0);
    ok = (s >= 1) && (s <= 3);
    if (ok) begin
      chk_resp("svc", 1'b0, 0);
      m_svc = s;
      if (s == 3) begin
        send(K_NONE, 0, 0);
        chk_resp("bal_enq", 1'b1, R_OK);
        check("bal_enq_val", 32'(balance_o), m_bal[m_id]);
      end
    end else begin
      chk_resp("svc_bad", 1'b1, R_BAD_REQ);
    end
  endtask

  task automatic t_amt(input int unsigned a, output bit ok);
    send(K_AMT, a, 0);
    ok = (a != 0);
    if (!ok) begin
      chk_resp("amt_zero", 1'b1, R_BAD_REQ);
    end else if (m_svc == 1) begin
      if (a + m_bal[m_id] > BAL_MAX) begin
        chk_resp("dep_ovf", 1'b1, R_OVERFLOW);
      end else begin
        chk_resp("dep_ok", 1'b1, R_OK);
        m_bal[m_id] = m_bal[m_id] + a;
      end
    end else begin
      if (a > m_bal[m_id]) begin
        chk_resp("wd_insuff", 1'b1, R_INSUFF);
      end else begin
        chk_resp("wd_ok", 1'b1, R_OK);
        m_bal[m_id] = m_bal[m_id] - a;
      end
    end
    check("amt_bal", 32'(balance_o), m_bal[m_id]);
  endtask

  task automatic t_more(input bit m);
    send(K_MORE, 32'(m), 0);
    chk_resp("more", 1'b0, 0);
    check("more_busy", 32'(busy), 1);
    if (!m) begin
      check("more_no_eject_yet", 32'(card_eject), 0);
      eject_seq("end");
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      send(K_NONE, 0, 0);
      chk_resp(tag, 1'b0, 0);
    end
  endtask

  task automatic rand_session();
    int id, st, n, s;
    int unsigned hi;
    bit ok;
    logic [PIN_W-1:0] wp;
    if ($urandom_range(3, 0) == 0) begin
      id = $urandom_range(NA - 1, 0);
      wp = PIN_W'($urandom);
      send(K_CFG, id, wp);
      m_pin[id] = wp;
      chk_resp("cfg", 1'b0, 0);
      check("cfg_busy", 32'(busy), 0);
    end
    id = $urandom_range(NA - 1, 0);
    t_card(id, ok);
    if (!ok) return;
    if ($urandom_range(3, 0) == 0) t_lang(($urandom_range(1, 0) == 0) ? 0 : 3, ok);
    t_lang($urandom_range(2, 1), ok);
    st = 1;
    while (st == 1) begin
      if ($urandom_range(2, 0) == 0) begin
        wp = m_pin[id] ^ PIN_W'($urandom_range(32'hFFFF, 1));
        t_pin(wp, st);
      end else begin
        t_pin(m_pin[id], st);
      end
    end
    if (st == 2) return;
    n = $urandom_range(3, 1);
    for (int k = 0; k < n; k++) begin
      send(K_AMT, 7, 0);
      chk_resp("stray_amt", 1'b0, 0);
      if ($urandom_range(3, 0) == 0) begin
        s = $urandom_range(4, 0);
        t_svc((s == 0) ? 0 : s + 3, ok);
      end
      s = $urandom_range(3, 1);
      t_svc(s, ok);
      if (s != 3) begin
        if ($urandom_range(4, 0) == 0) t_amt(0, ok);
        if (s == 1) begin
          t_amt($urandom_range(200, 1), ok);
        end else begin
          hi = m_bal[id] + 30;
          if (hi > BAL_MAX) hi = BAL_MAX;
          t_amt($urandom_range(hi, 1), ok);
        end
      end
      t_more(k < n - 1);
    end
  endtask

  initial begin
    bit ok;
    int st;
    rst_n = 1'b0;
    card_valid = 1'b0; lang_valid = 1'b0; pin_valid = 1'b0; svc_valid = 1'b0;
    amt_valid = 1'b0; more_valid = 1'b0; cfg_we = 1'b0;
    card_id = '0; lang = '0; pin = '0; svc = '0; amt = '0; more = 1'b0;
    cfg_idx = '0; cfg_pin = '0;
    model_reset();
    m_id = 0; m_svc = 0; m_tries = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_code", 32'(resp_code), 0);
    check("rst_balance", 32'(balance_o), 0);
    check("rst_lang", 32'(lang_o), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_eject", 32'(card_eject), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // normal deposit on card 2
    send(K_CFG, 2, 32'h1234);
    m_pin[2] = 16'h1234;
    check("cfg_busy", 32'(busy), 0);
    t_card(2, ok);
    t_lang(1, ok);
    t_pin(16'h1234, st);
    t_svc(1, ok);
    t_amt(50, ok);
    check("dep_150", 32'(balance_o), 150);
    t_more(1'b0);

    // withdraw limits on card 3
    t_card(3, ok);
    t_lang(2, ok);
    t_pin(16'h0000, st);
    t_svc(2, ok);
    t_amt(101, ok);
    check("wd_101_bal", 32'(balance_o), 100);
    t_more(1'b1);
    t_svc(2, ok);
    t_amt(100, ok);
    check("wd_100_bal", 32'(balance_o), 0);
    t_more(1'b0);

    // deposit overflow on card 0
    t_card(0, ok);
    t_lang(1, ok);
    t_pin(16'h0000, st);
    t_svc(1, ok);
    t_amt(100, ok);
    t_more(1'b1);
    t_svc(1, ok);
    t_amt(56, ok);
    check("ovf_bal", 32'(balance_o), 200);
    t_more(1'b1);
    t_svc(1, ok);
    t_amt(55, ok);
    check("dep_255", 32'(balance_o), 255);
    t_more(1'b1);
    t_svc(3, ok);
    t_more(1'b0);

    // lockout on card 1
    t_card(1, ok);
    t_lang(1, ok);
    for (int i = 0; i < MAX_TRIES; i++) t_pin(16'h5555, st);
    check("lock_card1", 32'(locked), 32'h2);
    t_card(1, ok);

    // timeout: tie in LANG, strobe on cycle 7 in SERVICE, then full expiry
    t_card(3, ok);
    idle_cycles(TMO - 1, "tie_wait");
    t_lang(1, ok);
    t_pin(16'h0000, st);
    idle_cycles(TMO - 2, "c7_wait");
    t_svc(5, ok);
    idle_cycles(TMO - 1, "tmo_wait");
    send(K_NONE, 0, 0);
    chk_resp("timeout", 1'b1, R_TIMEOUT);
    check("timeout_busy", 32'(busy), 1);
    eject_seq("tmo_eject");

    // reset while in WITHDRAW
    t_card(2, ok);
    t_lang(2, ok);
    t_pin(16'h1234, st);
    t_svc(2, ok);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_bal", 32'(balance_o), 0);
    check("mid_rst_locked", 32'(locked), 0);
    check("mid_rst_eject", 32'(card_eject), 0);
    rst_n = 1'b1;
    idle_cycles(2, "post_rst");
    check("post_rst_eject", 32'(card_eject), 0);

    // config write and card in the same IDLE cycle
    send(K_CFG_CARD, 2, 32'hBEEF);
    m_pin[2] = 16'hBEEF;
    chk_resp("cfg_card", 1'b0, 0);
    check("cfg_card_busy", 32'(busy), 0);
    t_card(2, ok);
    t_lang(1, ok);
    t_pin(16'hBEEF, st);
    check("cfg_pin_taken", 32'(st), 0);
    t_svc(3, ok);
    t_more(1'b0);

    for (int i = 0; i < 40; i++) rand_session();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
